// File: rtl/rv_exwb.sv
// rtl/rv_exwb.sv - EX->WB stage: result register, multi-cycle op sequencing, stall counter
// Optional macro RV_EXWB_FWD_EN enables the same-cycle WB forwarding outputs.
module rv_exwb #(
  parameter int XLEN   = 32,
  parameter int MAXCYC = 40
) (
  input  logic            clk,
  input  logic            xreset,
  input  logic            rdy,
  input  logic            ex_valid,
  input  logic            ex_wen,
  input  logic [4:0]      ex_rd,
  input  logic            ex_ld,
  input  logic            ex_mulop,
  input  logic            ex_cmpl,
  input  logic [XLEN-1:0] ex_rwdat,
  input  logic [XLEN-1:0] dmem_rdat,
  output logic            stall,
  output logic            rf_we,
  output logic [4:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic            fwd_vld,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_dat,
  output logic            tmo_err,
  output logic [31:0]     stall_cnt
);

  typedef enum logic {IDLE, MWAIT} state_t;

  localparam int WDW = $clog2(MAXCYC + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(MAXCYC);
  localparam logic [WDW-1:0] WD_ONE = WDW'(1);

  state_t          r_state;
  logic [WDW-1:0]  r_wd;
  logic            r_wb_wen;
  logic            r_wb_ld;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_rwdat;
  logic            r_tmo_err;
  logic [31:0]     r_stall_cnt;

  logic w_mul_start;
  logic w_wd_hit;
  logic w_stall;

  assign w_mul_start = ex_valid & ex_mulop & ~ex_cmpl;
  assign w_wd_hit    = (r_wd == WD_MAX);

  // Reset forces stall low even while EX still presents a pending multi-cycle op.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      IDLE:    w_stall = w_mul_start;
      MWAIT:   w_stall = ~ex_cmpl & ~w_wd_hit;
      default: w_stall = 1'b0;
    endcase
    w_stall = w_stall & xreset;
  end

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_state     <= IDLE;
      r_wd        <= '0;
      r_wb_wen    <= 1'b0;
      r_wb_ld     <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_rwdat  <= '0;
      r_tmo_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else if (rdy) begin
      if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
      case (r_state)
        IDLE: begin
          if (w_mul_start) begin
            r_state  <= MWAIT;
            r_wd     <= WD_ONE;
            r_wb_wen <= 1'b0;
            r_wb_ld  <= 1'b0;
          end else if (ex_valid) begin
            r_wb_wen   <= ex_wen;
            r_wb_ld    <= ex_ld;
            r_wb_rd    <= ex_rd;
            r_wb_rwdat <= ex_rwdat;
          end else begin
            r_wb_wen <= 1'b0;
            r_wb_ld  <= 1'b0;
          end
        end
        MWAIT: begin
          if (ex_cmpl) begin
            r_state    <= IDLE;
            r_wd       <= '0;
            r_wb_wen   <= ex_wen;
            r_wb_ld    <= ex_ld;
            r_wb_rd    <= ex_rd;
            r_wb_rwdat <= ex_rwdat;
          end else if (w_wd_hit) begin
            r_state    <= IDLE;
            r_wd       <= '0;
            r_tmo_err  <= 1'b1;
            r_wb_wen   <= 1'b0;
            r_wb_ld    <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_rwdat <= '0;
          end else begin
            r_wd <= r_wd + WD_ONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stall     = w_stall;
  assign rf_we     = r_wb_wen & (r_wb_rd != 5'd0);
  assign rf_wa     = r_wb_rd;
  assign rf_wd     = r_wb_ld ? dmem_rdat : r_wb_rwdat;
  assign tmo_err   = r_tmo_err;
  assign stall_cnt = r_stall_cnt;

`ifdef RV_EXWB_FWD_EN
  assign fwd_vld = rf_we;
  assign fwd_rd  = rf_wa;
  assign fwd_dat = rf_wd;
`else
  assign fwd_vld = 1'b0;
  assign fwd_rd  = 5'd0;
  assign fwd_dat = '0;
`endif

endmodule
